// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on valid/ready and shifts it out MSB-first.
// Define PISO_PARITY_EN to append one even-parity bit after the data bits of every word.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             last_cycle;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

`ifdef PISO_PARITY_EN
  assign last_cycle = (state_q == PARITY);
`else
  assign last_cycle = (state_q == SHIFT) && (cnt_q == '0);
`endif

  assign load_ready = !reset && ((state_q == IDLE) || last_cycle);
  assign accept     = load_valid && load_ready;

  // Outputs are precomputed from the next state so they leave the block straight from flops.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d = SHIFT;
      shreg_d = load_data;
      cnt_d   = CNT_LAST;
`ifdef PISO_PARITY_EN
      par_d   = ^load_data;
`endif
    end

    out_d       = 1'b0;
    out_valid_d = (state_d != IDLE);
    done_d      = 1'b0;
    if (state_d == SHIFT) begin
      out_d = shreg_d[WIDTH-1];
`ifndef PISO_PARITY_EN
      done_d = (cnt_d == '0);
`endif
    end
`ifdef PISO_PARITY_EN
    if (state_d == PARITY) begin
      out_d  = par_d;
      done_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef PISO_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed scenarios plus random traffic against a bit-queue model.
// The model holds the serial bits still to appear on the line; honours PISO_PARITY_EN if defined.
module tb_piso_tx;
  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int PERIOD = WIDTH + 1;
`else
  localparam int PERIOD = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             out;
  logic             out_valid;
  logic             done;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .out       (out),
    .out_valid (out_valid),
    .done      (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, got, expv, $time);
    end
  endtask

  // One clock: drive inputs, check the handshake, advance the model over the edge, check the line.
  task automatic applyStimulus(input logic rst, input logic lv, input logic [WIDTH-1:0] data);
    logic ready_m;
    logic accept;
    reset      = rst;
    load_valid = lv;
    load_data  = data;
    #1;
    ready_m = !rst && (exp_q.size() <= 1);
    checkOutput("load_ready", {31'd0, load_ready}, {31'd0, ready_m});
    accept = lv && ready_m;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (accept) begin
        for (int k = WIDTH - 1; k >= 0; k--) exp_q.push_back(data[k]);
`ifdef PISO_PARITY_EN
        exp_q.push_back(^data);
`endif
      end
    end
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    checkOutput("out", {31'd0, out}, {31'd0, (exp_q.size() > 0) ? exp_q[0] : 1'b0});
    checkOutput("done", {31'd0, done}, {31'd0, exp_q.size() == 1});
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);

    // Single word then idle.
    applyStimulus(1'b0, 1'b1, WIDTH'(4'hB));
    for (int i = 0; i < PERIOD + 1; i++) applyStimulus(1'b0, 1'b0, '0);

    // Back-to-back words with load_valid held high.
    applyStimulus(1'b0, 1'b1, WIDTH'(4'hB));
    for (int i = 0; i < PERIOD; i++) applyStimulus(1'b0, 1'b1, WIDTH'(4'h6));
    for (int i = 0; i < PERIOD + 1; i++) applyStimulus(1'b0, 1'b0, '0);

    // A word offered while busy must be ignored.
    applyStimulus(1'b0, 1'b1, WIDTH'(4'hF));
    applyStimulus(1'b0, 1'b1, '0);
    for (int i = 0; i < PERIOD - 2; i++) applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);

    // Reset in the middle of a word, then a fresh word.
    applyStimulus(1'b0, 1'b1, WIDTH'(4'h9));
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, WIDTH'(4'h5));
    for (int i = 0; i < PERIOD + 1; i++) applyStimulus(1'b0, 1'b0, '0);

    // Random traffic, including junk offered while busy and occasional resets.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), WIDTH'($urandom));
    end
    for (int i = 0; i < PERIOD + 1; i++) applyStimulus(1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
